// File: rtl/blake2_pkg.sv
// Shared constants and types for the BLAKE2 message front end.
// Block geometry and the feeder FSM state type live here so the core and feeder agree.
package blake2_pkg;

   localparam int BLOCK_BYTES = 64;
   localparam int BLOCK_IDX_W = 6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PAD  = 3'd2,
      S_HOLD = 3'd3,
      S_WAIT = 3'd4
   } feeder_state_e;

endpackage

// File: rtl/blake2_msg_feeder.sv
// Slices a length-announced byte stream into zero-padded 64-byte blocks and
// drives the BLAKE2 core's byte-load port, pacing itself on the core's ready.
//
// state  | meaning
// S_IDLE | waiting for start_i; len_i is latched on start
// S_LOAD | forwarding message bytes while the core is ready
// S_PAD  | message exhausted, emitting 0x00 up to byte index 63
// S_HOLD | one cycle while the core consumes byte 63 and still shows ready
// S_WAIT | core compressing; resume next block or finish the message
module blake2_msg_feeder
   import blake2_pkg::*;
#(
   parameter int BB    = 128,
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             byte_v_i,
   input  logic [7:0]       byte_i,
   output logic             byte_ready_o,
   input  logic             core_ready_i,
   output logic             data_v_o,
   output logic [5:0]       data_idx_o,
   output logic [7:0]       data_o,
   output logic             block_first_o,
   output logic             block_last_o,
   output logic [BB-1:0]    ll_o,
   output logic             msg_done_o
);

   localparam logic [LEN_W-1:0]       BLK_LEN = LEN_W'(BLOCK_BYTES);
   localparam logic [LEN_W-1:0]       ONE_LEN = LEN_W'(1);
   localparam logic [BLOCK_IDX_W-1:0] IDX_MAX = '1;

   feeder_state_e          state_q, state_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic [BLOCK_IDX_W-1:0] idx_q, idx_d;
   logic                   first_q, first_d;
   logic                   last_q, last_d;
   logic [BB-1:0]          ll_q, ll_d;
   logic                   data_v_q, data_v_d;
   logic [5:0]             data_idx_q, data_idx_d;
   logic [7:0]             data_q, data_d;
   logic                   done_q, done_d;

   logic load_fire;
   logic pad_fire;
   logic fire;

   assign load_fire = (state_q == S_LOAD) & byte_v_i & core_ready_i;
   assign pad_fire  = (state_q == S_PAD) & core_ready_i;
   assign fire      = load_fire | pad_fire;

   assign byte_ready_o = (state_q == S_LOAD) & core_ready_i;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      idx_d      = idx_q;
      first_d    = first_q;
      last_d     = last_q;
      ll_d       = ll_q;
      data_v_d   = 1'b0;
      data_idx_d = data_idx_q;
      data_d     = data_q;
      done_d     = 1'b0;

      if (fire) begin
         data_v_d   = 1'b1;
         data_idx_d = idx_q;
         data_d     = load_fire ? byte_i : 8'h00;
         idx_d      = idx_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = len_i;
               ll_d    = {{(BB-LEN_W){1'b0}}, len_i};
               first_d = 1'b1;
               last_d  = (len_i <= BLK_LEN);
               idx_d   = '0;
               state_d = (len_i != '0) ? S_LOAD : S_PAD;
            end
         end
         S_LOAD: begin
            if (load_fire) begin
               rem_d = rem_q - ONE_LEN;
               // Byte 63 wins over running out: an exact multiple needs no pad block.
               if (idx_q == IDX_MAX) begin
                  state_d = S_HOLD;
               end else if (rem_q == ONE_LEN) begin
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            if (pad_fire && idx_q == IDX_MAX) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_ready_i) begin
               if (last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  first_d = 1'b0;
                  last_d  = (rem_q <= BLK_LEN);
                  idx_d   = '0;
                  state_d = S_LOAD;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         idx_q      <= '0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         ll_q       <= '0;
         data_v_q   <= 1'b0;
         data_idx_q <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         idx_q      <= idx_d;
         first_q    <= first_d;
         last_q     <= last_d;
         ll_q       <= ll_d;
         data_v_q   <= data_v_d;
         data_idx_q <= data_idx_d;
         data_q     <= data_d;
         done_q     <= done_d;
      end
   end

   assign data_v_o      = data_v_q;
   assign data_idx_o    = data_idx_q;
   assign data_o        = data_q;
   assign block_first_o = first_q;
   assign block_last_o  = last_q;
   assign ll_o          = ll_q;
   assign msg_done_o    = done_q;

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Randomized bench for blake2_msg_feeder: a block-level model of the padded
// message plus a ready/busy core model, checked on every output byte.
module tb_blake2_msg_feeder;

   localparam int BB    = 128;
   localparam int LEN_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start_i;
   logic [LEN_W-1:0] len_i;
   logic             byte_v_i;
   logic [7:0]       byte_i;
   logic             byte_ready_o;
   logic             core_ready_i;
   logic             data_v_o;
   logic [5:0]       data_idx_o;
   logic [7:0]       data_o;
   logic             block_first_o;
   logic             block_last_o;
   logic [BB-1:0]    ll_o;
   logic             msg_done_o;

   blake2_msg_feeder #(.BB(BB), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_v_i     (byte_v_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .core_ready_i (core_ready_i),
      .data_v_o     (data_v_o),
      .data_idx_o   (data_idx_o),
      .data_o       (data_o),
      .block_first_o(block_first_o),
      .block_last_o (block_last_o),
      .ll_o         (ll_o),
      .msg_done_o   (msg_done_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [5:0] idx;
      logic [7:0] data;
      logic       first;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] msg_mem [0:1023];
   logic [7:0] cap_data[$];
   logic       cap_first[$];
   logic       cap_last[$];
   int         cur_len = 0;
   int         done_cnt = 0;
   logic       mon_en = 1'b0;

   // Core model: after it sees byte 63 it compresses for 100 cycles with ready low.
   int busy;
   always @(posedge clk or posedge reset) begin
      if (reset) busy <= 0;
      else if (data_v_o && data_idx_o == 6'd63) busy <= 100;
      else if (busy > 0) busy <= busy - 1;
   end
   assign core_ready_i = (busy == 0);

   logic prev_ready = 1'b1;
   logic prev_v63 = 1'b0;
   exp_t e;

   always @(negedge clk) begin
      if (reset || !mon_en) begin
         prev_ready = 1'b1;
         prev_v63   = 1'b0;
      end else begin
         if (data_v_o) begin
            // A byte is only legal if the core was ready and not swallowing byte 63.
            chk("fire_when_core_ready", {prev_ready, prev_v63}, 2'b10);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_fire: got idx %0d data %0h expected no byte", data_idx_o, data_o);
            end else begin
               e = exp_q.pop_front();
               chk("data_idx", data_idx_o, e.idx);
               chk("data", data_o, e.data);
               chk("block_first", block_first_o, e.first);
               chk("block_last", block_last_o, e.last);
               chk("ll", ll_o, 128'(cur_len));
            end
            cap_data.push_back(data_o);
            cap_first.push_back(block_first_o);
            cap_last.push_back(block_last_o);
         end
         if (!core_ready_i) chk("byte_ready_while_busy", byte_ready_o, 1'b0);
         if (msg_done_o) begin
            done_cnt++;
            chk("done_after_last_byte", exp_q.size(), 0);
         end
         prev_ready = core_ready_i;
         prev_v63   = data_v_o && (data_idx_o == 6'd63);
      end
   end

   // mode 0: random bytes, mode 1: "abc". abort_at>0 stops once that many bytes came out.
   task automatic run_msg(input int len, input int duty, input int mode,
                          input int abort_at, input bit spurious);
      int nb;
      int pos;
      int ptr;
      int cyc;
      int limit;
      bit aborted;
      bit sp_done;
      exp_t x;
      for (int i = 0; i < len; i++) msg_mem[i] = 8'($urandom);
      if (mode == 1) begin
         msg_mem[0] = 8'h61;
         msg_mem[1] = 8'h62;
         msg_mem[2] = 8'h63;
      end
      nb = (len == 0) ? 1 : (len + 63) / 64;
      exp_q.delete();
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < 64; i++) begin
            pos     = b * 64 + i;
            x.idx   = 6'(i);
            x.data  = (pos < len) ? msg_mem[pos] : 8'h00;
            x.first = (b == 0);
            x.last  = (b == nb - 1);
            exp_q.push_back(x);
         end
      end
      cap_data.delete();
      cap_first.delete();
      cap_last.delete();
      done_cnt = 0;
      cur_len  = len;
      mon_en   = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      len_i   = LEN_W'(len);
      @(negedge clk);
      start_i = 1'b0;
      len_i   = $urandom;
      ptr = 0;
      cyc = 0;
      aborted = 1'b0;
      sp_done = 1'b0;
      limit = nb * 400 + 200;
      while (1) begin
         if (ptr >= len && done_cnt > 0) break;
         if (abort_at > 0 && cap_data.size() >= abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (cyc > limit) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: len %0d sent %0d of %0d bytes, done %0d", len, ptr, len, done_cnt);
            break;
         end
         if (spurious && ptr == 10 && !sp_done) begin
            start_i = 1'b1;
            len_i   = 32'd7;
            sp_done = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         if (ptr < len) begin
            byte_v_i = ($urandom_range(99) >= duty);
            byte_i   = msg_mem[ptr];
            if (byte_v_i && byte_ready_o) ptr++;
         end else begin
            byte_v_i = 1'($urandom_range(1));
            byte_i   = 8'($urandom);
            if (byte_v_i) chk("no_extra_accept", byte_ready_o, 1'b0);
         end
         @(negedge clk);
         cyc++;
      end
      start_i  = 1'b0;
      byte_v_i = 1'b0;
      if (!aborted) begin
         repeat (4) @(negedge clk);
         chk("done_once", done_cnt, 1);
         chk("model_drained", exp_q.size(), 0);
         chk("byte_count", cap_data.size(), nb * 64);
         chk("ll_held", ll_o, 128'(len));
      end
   endtask

   int nz;

   initial begin
      reset    = 1'b1;
      start_i  = 1'b0;
      len_i    = '0;
      byte_v_i = 1'b0;
      byte_i   = '0;
      repeat (3) @(negedge clk);
      chk("rst_data_v", data_v_o, 1'b0);
      chk("rst_data_idx", data_idx_o, 6'd0);
      chk("rst_data", data_o, 8'h00);
      chk("rst_first_last", {block_first_o, block_last_o}, 2'b00);
      chk("rst_ll", ll_o, 128'd0);
      chk("rst_done", msg_done_o, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      byte_v_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_byte_ready", byte_ready_o, 1'b0);
      end
      byte_v_i = 1'b0;

      // Empty message: one all-zero block.
      run_msg(0, 0, 0, 0, 1'b0);
      nz = 0;
      foreach (cap_data[i]) if (cap_data[i] != 8'h00) nz++;
      chk("len0_all_zero", nz, 0);
      chk("len0_fires", cap_data.size(), 64);
      if (cap_data.size() == 64) chk("len0_first_last", {cap_first[0], cap_last[63]}, 2'b11);

      run_msg(3, 0, 1, 0, 1'b0);
      if (cap_data.size() >= 4)
         chk("abc_bytes", {cap_data[0], cap_data[1], cap_data[2], cap_data[3]}, 32'h61626300);

      run_msg(64, 0, 0, 0, 1'b0);
      if (cap_data.size() == 64) chk("len64_last", cap_last[0], 1'b1);

      run_msg(65, 10, 0, 0, 1'b0);
      if (cap_data.size() == 128) begin
         chk("len65_blk0_last", cap_last[0], 1'b0);
         chk("len65_blk1_flags", {cap_first[64], cap_last[64]}, 2'b01);
         chk("len65_blk1_pad", cap_data[65], 8'h00);
      end

      run_msg(130, 30, 0, 0, 1'b1);
      run_msg(128, 20, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) run_msg($urandom_range(200), $urandom_range(50), 0, 0, 1'b0);

      // Reset in the middle of block 1, then a clean "abc".
      run_msg(130, 30, 0, 64 + 21, 1'b0);
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_outputs", {data_v_o, block_first_o, block_last_o, msg_done_o, byte_ready_o}, 5'b0);
      chk("midrst_ll", ll_o, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      run_msg(3, 0, 1, 0, 1'b0);
      if (cap_data.size() >= 3)
         chk("abc_after_reset", {cap_data[0], cap_data[1], cap_data[2]}, 24'h616263);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
